// File: rtl/ram_loader.sv
// Serial program loader that owns the RAM write port: passes CPU accesses through when idle,
// otherwise writes framed payload bytes to sequential RAM addresses and verifies a checksum.
module ram_loader #(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic [12:0] cpu_address,
   input  logic        cpu_w_en,
   input  logic [7:0]  cpu_din,
   output logic [12:0] ram_address,
   output logic        ram_w_en,
   output logic [7:0]  ram_din,
   output logic        cpu_hold,
   output logic        load_done,
   output logic        load_err
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0] SYNC_BYTE = 8'h55;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ADDR_HI = 3'd1,
      S_ADDR_LO = 3'd2,
      S_LEN_HI  = 3'd3,
      S_LEN_LO  = 3'd4,
      S_DATA    = 3'd5,
      S_CSUM    = 3'd6
   } state_t;

   state_t           state_r;
   logic [12:0]      addr_r;
   logic [15:0]      remain_r;
   logic [7:0]       sum_r;
   logic [CNT_W-1:0] idle_cnt_r;
   logic             wr_pend_r;
   logic [12:0]      wr_addr_r;
   logic [7:0]       wr_data_r;
   logic             load_done_r;
   logic             load_err_r;

   // Frame passes when the data sum plus the trailing byte is zero modulo 256.
   function automatic logic csum_ok(input logic [7:0] sum, input logic [7:0] csum);
      logic [7:0] total;
      total = sum + csum;
      return (total == 8'h00);
   endfunction

   // Frame parser, inter-byte timeout and registered write/status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_IDLE;
         addr_r      <= 13'h0000;
         remain_r    <= 16'h0000;
         sum_r       <= 8'h00;
         idle_cnt_r  <= '0;
         wr_pend_r   <= 1'b0;
         wr_addr_r   <= 13'h0000;
         wr_data_r   <= 8'h00;
         load_done_r <= 1'b0;
         load_err_r  <= 1'b0;
      end else begin
         wr_pend_r   <= 1'b0;
         load_done_r <= 1'b0;

         // A byte arriving on the limit cycle keeps the frame alive.
         if (state_r == S_IDLE || rx_valid) begin
            idle_cnt_r <= '0;
         end else if (idle_cnt_r == IDLE_LIMIT) begin
            idle_cnt_r <= '0;
            state_r    <= S_IDLE;
            load_err_r <= 1'b1;
         end else begin
            idle_cnt_r <= idle_cnt_r + CNT_W'(1);
         end

         if (rx_valid) begin
            case (state_r)
               S_IDLE: begin
                  if (rx_data == SYNC_BYTE) begin
                     state_r    <= S_ADDR_HI;
                     load_err_r <= 1'b0;
                     sum_r      <= 8'h00;
                  end
               end
               S_ADDR_HI: begin
                  addr_r[12:8] <= rx_data[4:0];
                  state_r      <= S_ADDR_LO;
               end
               S_ADDR_LO: begin
                  addr_r[7:0] <= rx_data;
                  state_r     <= S_LEN_HI;
               end
               S_LEN_HI: begin
                  remain_r[15:8] <= rx_data;
                  state_r        <= S_LEN_LO;
               end
               S_LEN_LO: begin
                  remain_r[7:0] <= rx_data;
                  if ({remain_r[15:8], rx_data} == 16'h0000) begin
                     state_r <= S_CSUM;
                  end else begin
                     state_r <= S_DATA;
                  end
               end
               S_DATA: begin
                  wr_pend_r <= 1'b1;
                  wr_addr_r <= addr_r;
                  wr_data_r <= rx_data;
                  addr_r    <= addr_r + 13'd1;
                  sum_r     <= sum_r + rx_data;
                  remain_r  <= remain_r - 16'd1;
                  if (remain_r == 16'd1) begin
                     state_r <= S_CSUM;
                  end
               end
               S_CSUM: begin
                  load_done_r <= 1'b1;
                  load_err_r  <= ~csum_ok(sum_r, rx_data);
                  state_r     <= S_IDLE;
               end
               default: begin
                  state_r <= S_IDLE;
               end
            endcase
         end
      end
   end

   // RAM port mux: CPU passthrough only when idle with no loader write outstanding.
   always_comb begin
      if (state_r == S_IDLE && !wr_pend_r) begin
         ram_address = cpu_address;
         ram_w_en    = cpu_w_en;
         ram_din     = cpu_din;
      end else begin
         ram_address = wr_addr_r;
         ram_w_en    = wr_pend_r;
         ram_din     = wr_data_r;
      end
   end

   assign cpu_hold  = (state_r != S_IDLE) || wr_pend_r;
   assign load_done = load_done_r;
   assign load_err  = load_err_r;

endmodule

// File: tb/tb_ram_loader.sv
// Table-driven bench for ram_loader plus hand-written timeout and reset sequences.
module tb_ram_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [12:0] cpu_address;
   logic        cpu_w_en;
   logic [7:0]  cpu_din;
   logic [12:0] ram_address;
   logic        ram_w_en;
   logic [7:0]  ram_din;
   logic        cpu_hold;
   logic        load_done;
   logic        load_err;

   int checks = 0;
   int errors = 0;

   ram_loader #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .cpu_address(cpu_address), .cpu_w_en(cpu_w_en), .cpu_din(cpu_din),
      .ram_address(ram_address), .ram_w_en(ram_w_en), .ram_din(ram_din),
      .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rv;
      logic [7:0]  rd;
      logic        cwe;
      logic        ew;
      logic [12:0] ea;
      logic [7:0]  ed;
      logic        eh;
      logic        edn;
      logic        ee;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic rv, logic [7:0] rd, logic cwe, logic ew, logic [12:0] ea,
                               logic [7:0] ed, logic eh, logic edn, logic ee);
      vec_t v;
      v.rv = rv; v.rd = rd; v.cwe = cwe; v.ew = ew; v.ea = ea; v.ed = ed;
      v.eh = eh; v.edn = edn; v.ee = ee;
      return v;
   endfunction

   // In-frame byte with no RAM write expected; CPU keeps trying to write.
   function automatic vec_t hv(logic [7:0] rd, logic ee);
      return mk(1'b1, rd, 1'b1, 1'b0, 13'h0000, 8'h00, 1'b1, 1'b0, ee);
   endfunction

   // In-frame byte while the previous data byte is being written.
   function automatic vec_t wv(logic [7:0] rd, logic [12:0] ea, logic [7:0] ed, logic ee);
      return mk(1'b1, rd, 1'b1, 1'b1, ea, ed, 1'b1, 1'b0, ee);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
   endtask

   initial begin
      // Good 3-byte load at 0x0010, with idle passthrough on the sync cycle.
      tbl.push_back(mk(1'b1, 8'h55, 1'b1, 1'b1, 13'h0123, 8'h5A, 1'b0, 1'b0, 1'b0));
      tbl.push_back(hv(8'h00, 1'b0));
      tbl.push_back(hv(8'h10, 1'b0));
      tbl.push_back(hv(8'h00, 1'b0));
      tbl.push_back(hv(8'h03, 1'b0));
      tbl.push_back(hv(8'hA9, 1'b0));
      tbl.push_back(wv(8'h01, 13'h0010, 8'hA9, 1'b0));
      tbl.push_back(wv(8'h60, 13'h0011, 8'h01, 1'b0));
      tbl.push_back(wv(8'hF6, 13'h0012, 8'h60, 1'b0));
      tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 13'h0123, 8'h5A, 1'b0, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 13'h0123, 8'h5A, 1'b0, 1'b0, 1'b0));
      // Same frame with a bad checksum.
      tbl.push_back(mk(1'b1, 8'h55, 1'b0, 1'b0, 13'h0123, 8'h5A, 1'b0, 1'b0, 1'b0));
      tbl.push_back(hv(8'h00, 1'b0));
      tbl.push_back(hv(8'h10, 1'b0));
      tbl.push_back(hv(8'h00, 1'b0));
      tbl.push_back(hv(8'h03, 1'b0));
      tbl.push_back(hv(8'hA9, 1'b0));
      tbl.push_back(wv(8'h01, 13'h0010, 8'hA9, 1'b0));
      tbl.push_back(wv(8'h60, 13'h0011, 8'h01, 1'b0));
      tbl.push_back(wv(8'h00, 13'h0012, 8'h60, 1'b0));
      tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 13'h0123, 8'h5A, 1'b0, 1'b1, 1'b1));
      tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 13'h0123, 8'h5A, 1'b0, 1'b0, 1'b1));
      // Wrap frame at 0x1FFF (addr_hi=0xFF) clears the sticky error on sync.
      tbl.push_back(mk(1'b1, 8'h55, 1'b0, 1'b0, 13'h0123, 8'h5A, 1'b0, 1'b0, 1'b1));
      tbl.push_back(hv(8'hFF, 1'b0));
      tbl.push_back(hv(8'hFF, 1'b0));
      tbl.push_back(hv(8'h00, 1'b0));
      tbl.push_back(hv(8'h02, 1'b0));
      tbl.push_back(hv(8'hAA, 1'b0));
      tbl.push_back(wv(8'hBB, 13'h1FFF, 8'hAA, 1'b0));
      tbl.push_back(wv(8'h9B, 13'h0000, 8'hBB, 1'b0));
      tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 13'h0123, 8'h5A, 1'b0, 1'b1, 1'b0));
      // Empty frame: no writes, done pulse, no error.
      tbl.push_back(mk(1'b1, 8'h55, 1'b0, 1'b0, 13'h0123, 8'h5A, 1'b0, 1'b0, 1'b0));
      tbl.push_back(hv(8'h00, 1'b0));
      tbl.push_back(hv(8'h00, 1'b0));
      tbl.push_back(hv(8'h00, 1'b0));
      tbl.push_back(hv(8'h00, 1'b0));
      tbl.push_back(hv(8'h00, 1'b0));
      tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 13'h0123, 8'h5A, 1'b0, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 13'h0123, 8'h5A, 1'b0, 1'b0, 1'b0));

      rst_n = 1'b0;
      rx_valid = 1'b0;
      rx_data = 8'h00;
      cpu_address = 13'h0123;
      cpu_w_en = 1'b1;
      cpu_din = 8'h5A;
      #12;
      chk("reset ram_w_en", 32'(ram_w_en), 32'h1);
      chk("reset ram_address", 32'(ram_address), 32'h0123);
      chk("reset ram_din", 32'(ram_din), 32'h5A);
      chk("reset cpu_hold", 32'(cpu_hold), 32'h0);
      chk("reset load_done", 32'(load_done), 32'h0);
      chk("reset load_err", 32'(load_err), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         rx_valid = tbl[i].rv;
         rx_data  = tbl[i].rd;
         cpu_w_en = tbl[i].cwe;
         #1;
         chk($sformatf("vec%0d ram_w_en", i), 32'(ram_w_en), 32'(tbl[i].ew));
         if (tbl[i].ew || !tbl[i].eh) begin
            chk($sformatf("vec%0d ram_address", i), 32'(ram_address), 32'(tbl[i].ea));
            chk($sformatf("vec%0d ram_din", i), 32'(ram_din), 32'(tbl[i].ed));
         end
         chk($sformatf("vec%0d cpu_hold", i), 32'(cpu_hold), 32'(tbl[i].eh));
         chk($sformatf("vec%0d load_done", i), 32'(load_done), 32'(tbl[i].edn));
         chk($sformatf("vec%0d load_err", i), 32'(load_err), 32'(tbl[i].ee));
      end
      @(negedge clk);
      rx_valid = 1'b0;
      cpu_w_en = 1'b0;

      // A byte landing on the last allowed idle cycle wins over the timeout.
      send(8'h55);
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (15) @(negedge clk);
      #1;
      chk("gap15 cpu_hold", 32'(cpu_hold), 32'h1);
      rx_valid = 1'b1;
      rx_data = 8'hFF;
      send(8'h10);
      send(8'h00);
      send(8'h03);
      @(negedge clk);
      rx_valid = 1'b0;
      // Stream stops after len_lo: abort exactly 16 clocks after the last byte.
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("timeout c%0d load_done", i), 32'(load_done), 32'h0);
         if (i < 16) begin
            chk($sformatf("timeout c%0d cpu_hold", i), 32'(cpu_hold), 32'h1);
         end else begin
            chk("timeout cpu_hold", 32'(cpu_hold), 32'h0);
            chk("timeout load_err", 32'(load_err), 32'h1);
         end
      end
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("post-timeout load_done", 32'(load_done), 32'h0);
      end

      // Reset asserted mid-DATA while a write strobe is active.
      send(8'h55);
      send(8'h00);
      send(8'h10);
      send(8'h00);
      send(8'h03);
      send(8'hA9);
      send(8'h01);
      @(posedge clk);
      #1;
      chk("pre-reset ram_w_en", 32'(ram_w_en), 32'h1);
      chk("pre-reset ram_address", 32'(ram_address), 32'h0011);
      chk("pre-reset ram_din", 32'(ram_din), 32'h01);
      #1;
      rx_valid = 1'b0;
      cpu_address = 13'h0456;
      cpu_din = 8'hC3;
      cpu_w_en = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("async reset ram_w_en", 32'(ram_w_en), 32'h0);
      chk("async reset ram_address", 32'(ram_address), 32'h0456);
      chk("async reset ram_din", 32'(ram_din), 32'hC3);
      chk("async reset cpu_hold", 32'(cpu_hold), 32'h0);
      chk("async reset load_done", 32'(load_done), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      cpu_w_en = 1'b1;
      #1;
      chk("after reset passthrough we", 32'(ram_w_en), 32'h1);
      chk("after reset passthrough addr", 32'(ram_address), 32'h0456);
      cpu_w_en = 1'b0;
      repeat (3) begin
         @(negedge clk);
         #1;
         chk("after reset no stray write", 32'(ram_w_en), 32'h0);
         chk("after reset cpu_hold", 32'(cpu_hold), 32'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_loader.md
# ram_loader

Byte-stream program loader that sits directly upstream of the 8 KB system RAM and owns its write port. In normal operation it passes the CPU's RAM address, data and write strobe straight through. When a framed load arrives on the serial receive byte stream, it holds the CPU, writes the payload bytes into RAM at sequential addresses and checks a trailing checksum. It is used to inject programs without a ROM rebuild.

## Interface
- `TIMEOUT_CYCLES`, default 1_000_000: maximum number of clocks allowed between bytes inside a frame before the frame is aborted.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rx_data` in 8: received byte from the UART receiver.
- `rx_valid` in 1: one-cycle strobe marking `rx_data` valid; may be asserted on back-to-back cycles.
- `cpu_address` in 13: CPU RAM address.
- `cpu_w_en` in 1: CPU write enable.
- `cpu_din` in 8: CPU write data.
- `ram_address` out 13: RAM address bus.
- `ram_w_en` out 1: RAM active-high write strobe.
- `ram_din` out 8: RAM write data.
- `cpu_hold` out 1: high while a frame is in progress; the CPU must stall.
- `load_done` out 1: one-cycle pulse when a frame completes, whether the checksum passed or failed.
- `load_err` out 1: sticky error flag; cleared when the next sync byte is accepted.

## Operation
- **Frame format:** `0x55` (sync), addr_hi, addr_lo, len_hi, len_lo, N data bytes, checksum.
  - The start address is {addr_hi[4:0], addr_lo}; addr_hi[7:5] are ignored.
  - N is {len_hi, len_lo}, range 0..65535.
- **State machine:** IDLE → ADDR_HI → ADDR_LO → LEN_HI → LEN_LO → DATA → CSUM → IDLE.
  - Each transition occurs only on `rx_valid`.
  - In IDLE, any byte other than `0x55` is ignored.
  - In LEN_LO, if N=0 the next state is CSUM.
- **DATA state:**
  - Each accepted byte is written to the current address.
  - The address then increments modulo 8192, so 0x1FFF wraps to 0x0000.
  - The remaining-byte counter decrements; when it reaches 0, the next state is CSUM.
- **Checksum:**
  - An 8-bit running sum of the data bytes is kept.
  - The frame passes if (sum + checksum byte) mod 256 = 0.
  - On failure, `load_err` is set. Bytes already written are not rolled back.
- **Inter-byte timeout:** In any state other than IDLE, an idle counter counts clocks without `rx_valid` and is reset by every `rx_valid`. When it reaches `TIMEOUT_CYCLES`, the loader:
  - returns to IDLE;
  - sets `load_err`;
  - does not pulse `load_done`.
- **Port multiplexing:**
  - In IDLE with no write pending, `ram_address`, `ram_w_en` and `ram_din` equal `cpu_address`, `cpu_w_en` and `cpu_din`, combinationally.
  - Otherwise the RAM port is driven from loader registers, and `cpu_w_en` is blocked.
  - `cpu_hold` = (state ≠ IDLE) or a write is pending.

## Timing
- **Reset:** All outputs go low, the state returns to IDLE, and the address, counters and sum clear to 0.
  - While in reset, the RAM port mirrors the CPU inputs.
- **Write latency:** When a DATA byte is accepted on cycle T, `ram_w_en`=1 on cycle T+1 for exactly one cycle, with `ram_address` = the write address and `ram_din` = the byte.
  - Back-to-back `rx_valid` produces back-to-back write cycles at consecutive addresses.
- **Last byte:** The final DATA byte's write still occurs on T+1, even though the state is already CSUM.
- **Completion:** The CSUM byte is accepted on cycle T. On T+1:
  - `load_done` pulses high;
  - `load_err` updates;
  - the state is IDLE and `cpu_hold` falls.
- **Sync and `load_err`:** Acceptance of a `0x55` sync byte in IDLE clears `load_err` and raises `cpu_hold` on the next cycle.
- **Timeout priority:** A timeout and an `rx_valid` can coincide on the same cycle; the `rx_valid` wins and the counter resets.
- **Reset during a frame:** Asserting `rst_n` low mid-frame aborts immediately, with no partial write strobe after reset assertion.
- **Write-enable guarantee:** `ram_w_en` is never high for more than one cycle per accepted data byte.

## Test plan
1. Load 3 bytes:
   - Stimulus: 55 00 10 00 03 A9 01 60 F6.
   - Required: writes A9, 01, 60 to 0x0010, 0x0011, 0x0012, each exactly one cycle after its `rx_valid`; `load_done` pulses once; `load_err`=0.
2. Wrap-around:
   - Stimulus: a frame with address 0x1FFF and 2 bytes AA BB.
   - Required: AA is written at 0x1FFF and BB at 0x0000.
   - Also: with addr_hi=0xFF, the start address is 0x1F??.
3. Bad checksum:
   - Stimulus: as in scenario 1, but with checksum 00.
   - Required: all 3 writes occur; `load_done` pulses and `load_err`=1.
   - Then: a following valid frame clears `load_err` on its sync byte.
4. Timeout:
   - Stimulus: `TIMEOUT_CYCLES`=16; stop the stream after len_lo.
   - Required: 16 clocks later the state is IDLE, `load_err`=1, no `load_done` pulse, `cpu_hold`=0.
5. Passthrough and hold:
   - In IDLE: `cpu_w_en`=1 at 0x0123 with data 5A appears on the RAM port in the same cycle.
   - Mid-frame: `cpu_w_en`=1 produces no `ram_w_en` unless from a loader byte, and `cpu_hold`=1.
6. Stress:
   - Stimulus: an N=0 frame (55 00 00 00 00 00) gives `load_done` with no writes.
   - Stimulus: `rst_n` asserted low during DATA.
   - Required: all outputs go to 0 asynchronously, and the port returns to passthrough.
